uart_rx_sink: RTL and testbench
===============================

// Module: uart_rx_sink
// PURPOSE
//  8N1 UART receiver paired with the system UART transmitter. It deserialises
//  uart_tx_o of ibex_demo_system, or any external TX line, into bytes.
//  Received bytes are buffered in a FIFO and drained over a valid/ready port.
//  Used in the top-level bench as a console sink, and on FPGA as the RX front end.
// PARAMETERS
//  ClockFrequency  50_000_000  system clock in Hz
//  BaudRate        115_200     line rate in bit/s
//  FifoDepth       8           byte FIFO entries; power of two, >= 2
//  Derived: ClksPerBit = ClockFrequency/BaudRate (truncated, 434 at defaults);
//  HalfBit = ClksPerBit/2 (217)
// PORTS
//  clk_sys_i     in   1                        system clock
//  rst_sys_ni    in   1                        reset, synchronous, active-low
//  uart_rx_i     in   1                        serial line, idle high, asynchronous
//  rx_data_o     out  8                        FIFO head byte
//  rx_valid_o    out  1                        FIFO not empty
//  rx_ready_i    in   1                        consumer accepts head byte
//  frame_err_o   out  1                        1-cycle pulse: stop bit sampled low
//  overflow_o    out  1                        1-cycle pulse: byte dropped, FIFO full
//  fifo_level_o  out  $clog2(FifoDepth+1)      current occupancy
// BEHAVIOUR
//  - Reset: all state is cleared while rst_sys_ni=0 at a clk_sys_i edge.
//    Outputs at reset: rx_data_o=0, rx_valid_o=0, frame_err_o=0, overflow_o=0,
//    fifo_level_o=0, FSM in IDLE. Synchronizer flops reset to 1.
//    Reset mid-frame abandons the frame; the partial byte is never pushed.
//  - uart_rx_i passes through a 2-flop synchronizer (rx_s) before any use.
//  - FSM: one baud counter, reloaded on each state entry.
//    IDLE : rx_s==0 -> START, counter=0.
//    START: at counter==HalfBit-1, sample rx_s.
//           If 1 (glitch) -> IDLE. If 0 -> DATA, bit index=0.
//    DATA : every ClksPerBit cycles, sample rx_s into shift[idx], LSB first.
//           After idx 7 is sampled -> STOP.
//    STOP : after ClksPerBit cycles, sample rx_s.
//           If 1: push the byte (or drop it if the FIFO is full) -> IDLE.
//           If 0: pulse frame_err_o, no push, -> BREAK.
//    BREAK: wait for rx_s==1 -> IDLE. Prevents a held-low line from
//           retriggering a start.
//  - FIFO push happens on the stop-sample cycle.
//    rx_valid_o/rx_data_o reflect the new byte on the following cycle.
//    Head data is registered; rx_data_o is stable while rx_valid_o=1 and
//    rx_ready_i=0.
//  - Pop occurs when rx_valid_o && rx_ready_i at a clock edge.
//    rx_ready_i while empty has no effect.
//  - Push and pop in the same cycle: both are performed and the level is
//    unchanged. This holds even when the FIFO is full (the pop frees the slot),
//    and no overflow is flagged.
//  - Push while full without a pop: the byte is discarded, overflow_o pulses,
//    and FIFO contents are unchanged.
//  - Pointers are log2(FifoDepth) bits and wrap modulo FifoDepth; the level
//    counter saturates at neither end because it cannot exceed its bounds.
//  - frame_err_o and overflow_o are registered 1-cycle pulses and never
//    assert outside those events.
// TESTING
//  1 Reset: hold rst_sys_ni=0 for 3 clks with uart_rx_i toggling.
//    -> rx_valid_o=0, fifo_level_o=0, no pulses.
//  2 Send 0x55, then 0xA3, at 115200 baud, with rx_ready_i=1.
//    -> rx_data_o shows 0x55 then 0xA3, each valid for 1 cycle.
//    -> frame_err_o and overflow_o stay 0.
//  3 Send 9 bytes 0x01..0x09 with rx_ready_i=0 (depth 8).
//    -> fifo_level_o=8, overflow_o pulses once on the 9th byte.
//    -> The drain then yields exactly 0x01..0x08.
//  4 Send 0x7E with the stop bit forced low, then hold the line low for
//    30 bit times, then release.
//    -> One frame_err_o pulse, level stays 0, no further start is detected.
//    -> A subsequent 0x42 is received correctly.
//  5 Pulse uart_rx_i low for 100 clks (less than HalfBit) while idle.
//    -> FSM returns to IDLE, nothing is pushed.
//  6 Fill to 8 entries, then assert rx_ready_i in the stop-sample cycle of
//    a 9th byte 0xC0.
//    -> No overflow, level stays 8, 0xC0 is the last byte drained.
//    Also: reset mid-DATA of 0xFF, then send 0x12.
//    -> Only 0x12 is received.

Source files
------------

// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling FSM and
// a byte FIFO drained over a valid/ready port.
module uart_rx_sink #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned FifoDepth      = 8
) (
  input  logic                               clk_sys_i,
  input  logic                               rst_sys_ni,
  input  logic                               uart_rx_i,
  output logic [7:0]                         rx_data_o,
  output logic                               rx_valid_o,
  input  logic                               rx_ready_i,
  output logic                               frame_err_o,
  output logic                               overflow_o,
  output logic [$clog2(FifoDepth+1)-1:0]     fifo_level_o
);

  localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned PtrW       = $clog2(FifoDepth);
  localparam int unsigned LvlW       = $clog2(FifoDepth + 1);

  localparam logic [CntW-1:0] HalfCnt = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitCnt  = CntW'(ClksPerBit - 1);
  localparam logic [LvlW-1:0] FullLvl = LvlW'(FifoDepth);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  logic [1:0]      sync_q, sync_d;
  logic            rx_s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  logic            push;

  logic [7:0]      mem_q [FifoDepth];
  logic [7:0]      mem_d [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            pop, full, push_acc;

  // uart_rx_i is asynchronous; only the second flop output is ever used.
  assign sync_d = {sync_q[0], uart_rx_i};
  assign rx_s   = sync_q[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == BitCnt) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (cnt_q == BitCnt) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // A line held low must return high before a new start is accepted.
        cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign full       = (level_q == FullLvl);
  assign rx_valid_o = (level_q != '0);
  assign pop        = rx_valid_o && rx_ready_i;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_acc   = push && (!full || pop);
  assign overflow_d = push && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_acc, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      sync_q      <= 2'b11;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mem_q       <= mem_d;
    end
  end

  assign rx_data_o    = mem_q[rd_ptr_q];
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_uart_rx_sink.sv
// Directed bench for uart_rx_sink; clock scaled so one bit is 16 clocks.
module tb_uart_rx_sink;

  localparam int unsigned ClockFrequency = 1_843_200;
  localparam int unsigned BaudRate       = 115_200;
  localparam int unsigned FifoDepth      = 8;
  localparam int unsigned Cpb            = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovf;
  logic [3:0] level;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned ferr_cnt = 0;
  int unsigned ovf_cnt = 0;
  int unsigned valid_cnt = 0;
  logic [7:0]  got[$];

  always #5 clk = ~clk;

  uart_rx_sink #(
    .ClockFrequency(ClockFrequency),
    .BaudRate      (BaudRate),
    .FifoDepth     (FifoDepth)
  ) dut (
    .clk_sys_i   (clk),
    .rst_sys_ni  (rst_n),
    .uart_rx_i   (rx_line),
    .rx_data_o   (data),
    .rx_valid_o  (valid),
    .rx_ready_i  (ready),
    .frame_err_o (ferr),
    .overflow_o  (ovf),
    .fifo_level_o(level)
  );

  // Record every accepted byte and every pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid && ready) got.push_back(data);
    if (valid) valid_cnt <= valid_cnt + 1;
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (ovf) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int unsigned n);
    rx_line = v;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, Cpb);
    for (int i = 0; i < 8; i++) hold(b[i], Cpb);
    hold(stop_bit, Cpb);
    rx_line = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_line = i[0];
      tick();
    end
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid);
    else pass_cnt++;
    total_cnt++;
    if (level !== 4'd0) $display("FAIL reset_level: got %0d expected 0", level);
    else pass_cnt++;
    total_cnt++;
    if (data !== 8'h00) $display("FAIL reset_data: got %02h expected 00", data);
    else pass_cnt++;
    total_cnt++;
    if ({ferr, ovf} !== 2'b00) $display("FAIL reset_pulses: got %b expected 00", {ferr, ovf});
    else pass_cnt++;
    rx_line = 1'b1;
    rst_n = 1'b1;
    repeat (2 * Cpb) tick();
    total_cnt++;
    if (valid !== 1'b0 || ferr_cnt != 0 || ovf_cnt != 0)
      $display("FAIL reset_idle: got valid=%b ferr=%0d ovf=%0d expected 0/0/0",
               valid, ferr_cnt, ovf_cnt);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int unsigned base = got.size();
    int unsigned v0 = valid_cnt;
    int unsigned f0 = ferr_cnt;
    int unsigned o0 = ovf_cnt;
    ready = 1'b1;
    send_byte(8'h55, 1'b1);
    repeat (4) tick();
    send_byte(8'hA3, 1'b1);
    repeat (4) tick();
    total_cnt++;
    if (got.size() != base + 2) $display("FAIL basic_count: got %0d expected 2", got.size() - base);
    else pass_cnt++;
    total_cnt++;
    if (got.size() < base + 2 || got[base] !== 8'h55 || got[base+1] !== 8'hA3)
      $display("FAIL basic_data: got %p expected 55 a3", got);
    else pass_cnt++;
    total_cnt++;
    if (valid_cnt - v0 != 2) $display("FAIL basic_valid_cycles: got %0d expected 2", valid_cnt - v0);
    else pass_cnt++;
    total_cnt++;
    if (ferr_cnt != f0 || ovf_cnt != o0)
      $display("FAIL basic_pulses: got ferr=%0d ovf=%0d expected 0/0", ferr_cnt - f0, ovf_cnt - o0);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int unsigned base = got.size();
    int unsigned o0 = ovf_cnt;
    ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b1);
      repeat (2) tick();
    end
    total_cnt++;
    if (level !== 4'd8) $display("FAIL ovf_level: got %0d expected 8", level);
    else pass_cnt++;
    total_cnt++;
    if (ovf_cnt - o0 != 1) $display("FAIL ovf_pulse: got %0d expected 1", ovf_cnt - o0);
    else pass_cnt++;
    total_cnt++;
    if (data !== 8'h01) $display("FAIL ovf_head: got %02h expected 01", data);
    else pass_cnt++;
    ready = 1'b1;
    repeat (12) tick();
    ready = 1'b0;
    total_cnt++;
    if (got.size() != base + 8) $display("FAIL ovf_drain_count: got %0d expected 8", got.size() - base);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (got.size() <= base + i || got[base+i] !== 8'(i + 1))
        $display("FAIL ovf_drain_%0d: got %p expected %02h", i, got, 8'(i + 1));
      else pass_cnt++;
    end
    total_cnt++;
    if (level !== 4'd0) $display("FAIL ovf_level_empty: got %0d expected 0", level);
    else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int unsigned base = got.size();
    int unsigned f0 = ferr_cnt;
    ready = 1'b1;
    send_byte(8'h7E, 1'b0);
    hold(1'b0, 30 * Cpb);
    hold(1'b1, 2 * Cpb);
    total_cnt++;
    if (ferr_cnt - f0 != 1) $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0);
    else pass_cnt++;
    total_cnt++;
    if (level !== 4'd0 || got.size() != base)
      $display("FAIL ferr_no_push: got level=%0d bytes=%0d expected 0/0", level, got.size() - base);
    else pass_cnt++;
    send_byte(8'h42, 1'b1);
    repeat (4) tick();
    total_cnt++;
    if (got.size() != base + 1 || got[base] !== 8'h42)
      $display("FAIL ferr_recover: got %p expected 42", got);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int unsigned base = got.size();
    int unsigned f0 = ferr_cnt;
    ready = 1'b1;
    hold(1'b0, 3);
    hold(1'b1, 2 * Cpb);
    total_cnt++;
    if (level !== 4'd0 || got.size() != base || ferr_cnt != f0)
      $display("FAIL glitch_ignored: got level=%0d bytes=%0d ferr=%0d expected 0/0/0",
               level, got.size() - base, ferr_cnt - f0);
    else pass_cnt++;
    send_byte(8'h3C, 1'b1);
    repeat (4) tick();
    total_cnt++;
    if (got.size() != base + 1 || got[base] !== 8'h3C)
      $display("FAIL glitch_recover: got %p expected 3c", got);
    else pass_cnt++;
  endtask

  task automatic test_full_pop();
    int unsigned base = got.size();
    int unsigned o0 = ovf_cnt;
    logic [7:0] exp_b;
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hB0 + 8'(i), 1'b1);
      repeat (2) tick();
    end
    total_cnt++;
    if (level !== 4'd8) $display("FAIL fullpop_fill: got %0d expected 8", level);
    else pass_cnt++;
    // Stop sample lands 155 clocks after the start edge is driven.
    fork
      send_byte(8'hC0, 1'b1);
      begin
        repeat (154) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
    join
    repeat (4) tick();
    total_cnt++;
    if (ovf_cnt != o0) $display("FAIL fullpop_no_ovf: got %0d expected 0", ovf_cnt - o0);
    else pass_cnt++;
    total_cnt++;
    if (level !== 4'd8) $display("FAIL fullpop_level: got %0d expected 8", level);
    else pass_cnt++;
    ready = 1'b1;
    repeat (12) tick();
    ready = 1'b0;
    total_cnt++;
    if (got.size() != base + 9) $display("FAIL fullpop_count: got %0d expected 9", got.size() - base);
    else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      exp_b = (i == 8) ? 8'hC0 : 8'hB0 + 8'(i);
      total_cnt++;
      if (got.size() <= base + i || got[base+i] !== exp_b)
        $display("FAIL fullpop_drain_%0d: got %p expected %02h", i, got, exp_b);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int unsigned base = got.size();
    int unsigned f0 = ferr_cnt;
    ready = 1'b1;
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (60) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
      end
    join
    repeat (4) tick();
    total_cnt++;
    if (level !== 4'd0 || got.size() != base)
      $display("FAIL rstmid_dropped: got level=%0d bytes=%0d expected 0/0", level, got.size() - base);
    else pass_cnt++;
    send_byte(8'h12, 1'b1);
    repeat (4) tick();
    total_cnt++;
    if (got.size() != base + 1 || got[base] !== 8'h12 || ferr_cnt != f0)
      $display("FAIL rstmid_next: got %p ferr=%0d expected 12 ferr=0", got, ferr_cnt - f0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
